// File: rtl/waterfall_fb_ctrl_pkg.sv
// Shared types and helpers for the waterfall
// framebuffer controller.
package waterfall_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    VIDEO,
    WRITE_ROW,
    WAIT_BLANK
  } state_t;

  // (a + b) mod m for a, b < m
  function automatic int unsigned mod_add(
    input int unsigned a,
    input int unsigned b,
    input int unsigned m
  );
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/waterfall_fb_ctrl_if.sv
// Row producer stream: one pixel per beat,
// valid/ready handshake.
interface waterfall_fb_ctrl_if #(
  parameter int PIX_BITS = 8
);
  logic                row_valid;
  logic [PIX_BITS-1:0] row_data;
  logic                row_ready;

  modport master (
    output row_valid,
    output row_data,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    output row_ready
  );
endinterface

// File: rtl/waterfall_fb_ctrl_fb_addr_gen.sv
// Registered framebuffer address: circular row
// window (row+top) wrapped at HEIGHT.
module fb_addr_gen #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int X_BITS    = $clog2(WIDTH),
  parameter int Y_BITS    = $clog2(HEIGHT),
  parameter int ADDR_BITS = $clog2(WIDTH*HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_en_i,
  input  logic [ADDR_BITS-1:0] clr_addr_i,
  input  logic [Y_BITS-1:0]    row_i,
  input  logic [X_BITS-1:0]    col_i,
  input  logic [Y_BITS-1:0]    top_i,
  output logic [ADDR_BITS-1:0] addr_o
);
  import waterfall_pkg::*;

  logic [ADDR_BITS-1:0] addr_d, addr_q;
  int unsigned          lin_idx;

  // Clear sweep overrides the windowed address
  always_comb begin
    lin_idx = mod_add(32'(row_i), 32'(top_i),
                      32'(HEIGHT));
    addr_d  = ADDR_BITS'(lin_idx * 32'(WIDTH)
                         + 32'(col_i));
    if (clr_en_i) addr_d = clr_addr_i;
  end

  // Address register
  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/waterfall_fb_ctrl.sv
// Scrolling waterfall framebuffer: clear, display
// reads and blank-time row insertion.
module waterfall_fb_ctrl #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int PIX_BITS   = 8,
  parameter int SCROLL_DIV = 4,
  parameter int X_BITS     = $clog2(WIDTH),
  parameter int Y_BITS     = $clog2(HEIGHT),
  parameter int ADDR_BITS  = $clog2(WIDTH*HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 visible,
  input  logic                 lower_blank,
  input  logic [X_BITS-1:0]    x,
  input  logic [Y_BITS-1:0]    y,
  waterfall_fb_ctrl_if.slave   row_if,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [PIX_BITS-1:0]  ram_wdata,
  output logic                 ram_we,
  input  logic [PIX_BITS-1:0]  ram_rdata,
  output logic [PIX_BITS-1:0]  pix_data,
  output logic                 clear_done
);
  import waterfall_pkg::*;

  localparam int FC_BITS =
    (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_A =
    ADDR_BITS'(WIDTH*HEIGHT-1);
  localparam logic [X_BITS-1:0] LAST_C =
    X_BITS'(WIDTH-1);
  localparam logic [FC_BITS-1:0] FC_MAX =
    FC_BITS'(SCROLL_DIV-1);
  localparam logic [Y_BITS-1:0] BOT =
    Y_BITS'(HEIGHT-1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_q, clr_d;
  logic [Y_BITS-1:0]    top_q, top_d;
  logic [X_BITS-1:0]    wcol_q, wcol_d;
  logic [FC_BITS-1:0]   fc_q, fc_d;
  logic                 lb_q;
  logic                 vis1_q, vis1_d, vis2_q;
  logic                 we_q, we_d;
  logic [PIX_BITS-1:0]  wdata_q, wdata_d;
  logic                 done_q, done_d;

  logic                 clr_en, rise, accept;
  logic [Y_BITS-1:0]    ag_row, wrow;
  logic [X_BITS-1:0]    ag_col;

  assign rise = lower_blank & ~lb_q;
  assign row_if.row_ready =
    (state_q == WRITE_ROW) && lower_blank;
  assign accept = row_if.row_ready && row_if.row_valid;
  assign wrow = Y_BITS'(mod_add(32'(top_q),
    32'(HEIGHT-1), 32'(HEIGHT)));

  // Next-state, write request and address select
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    top_d   = top_q;
    wcol_d  = wcol_q;
    fc_d    = fc_q;
    we_d    = 1'b0;
    wdata_d = '0;
    done_d  = done_q | (state_q != CLEAR);
    vis1_d  = visible && (state_q == VIDEO ||
                          state_q == WAIT_BLANK);
    clr_en  = 1'b0;
    ag_row  = y;
    ag_col  = x;
    unique case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        we_d   = 1'b1;
        if (clr_q == LAST_A) state_d = VIDEO;
        else clr_d = clr_q + 1'b1;
      end
      VIDEO: begin
        if (rise) begin
          if (fc_q != FC_MAX) fc_d = fc_q + 1'b1;
          if (fc_q == FC_MAX || wcol_q != '0)
            state_d = WRITE_ROW;
        end
      end
      WRITE_ROW: begin
        ag_row = BOT;
        ag_col = wcol_q;
        if (!lower_blank) begin
          state_d = VIDEO;
        end else if (accept) begin
          we_d    = 1'b1;
          wdata_d = row_if.row_data;
          if (wcol_q == LAST_C) begin
            top_d   = wrow;
            wcol_d  = '0;
            fc_d    = '0;
            state_d = WAIT_BLANK;
          end else begin
            wcol_d = wcol_q + 1'b1;
          end
        end
      end
      WAIT_BLANK: begin
        if (!lower_blank) state_d = VIDEO;
      end
      default: state_d = CLEAR;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      top_q   <= '0;
      wcol_q  <= '0;
      fc_q    <= '0;
      lb_q    <= 1'b0;
      vis1_q  <= 1'b0;
      vis2_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      top_q   <= top_d;
      wcol_q  <= wcol_d;
      fc_q    <= fc_d;
      lb_q    <= lower_blank;
      vis1_q  <= vis1_d;
      vis2_q  <= vis1_q;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  fb_addr_gen #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .clr_en_i   (clr_en),
    .clr_addr_i (clr_q),
    .row_i      (ag_row),
    .col_i      (ag_col),
    .top_i      (top_q),
    .addr_o     (ram_addr)
  );

  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;
  assign clear_done = done_q;
  assign pix_data   = vis2_q ? ram_rdata : '0;

endmodule
